// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// The optional stall performance counters use PERF_W (see ARB_PERF_CNT_EN in the top).
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned MEM_LAT_DEF    = 2;
  localparam int unsigned STARVE_MAX_DEF = 3;

  // Latency timer sized for the largest legal MEM_LAT (4) plus zero.
  localparam int unsigned LAT_CNT_W = $clog2(5);
  localparam int unsigned STARVE_W  = 3;
  localparam int unsigned PERF_W    = 16;

  typedef enum logic {
    ST_IDLE,
    ST_RD_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  function automatic logic [PERF_W-1:0] perf_sat_inc(input logic [PERF_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Read-latency timer: loaded at read grant, counts down while the arbiter waits,
// and flags the cycle in which the count reaches zero (memory data is valid then).
module mem_lat_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned LOAD_VAL = MEM_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic active_i,
  output logic done_o
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LAT_CNT_W'(LOAD_VAL);
    end else if (active_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The decrement taken this cycle is the one that lands on zero.
  assign done_o = active_i && (cnt_q == LAT_CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between fetch (IF) and load/store (DM).
// Define ARB_PERF_CNT_EN to add saturating stall-cycle counters on two extra ports.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,

  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              stall_if_o,
  output logic              stall_dm_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_if_stall_o,
  output logic [PERF_W-1:0] perf_dm_stall_o
`endif
);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
  logic                if_rvalid_q, dm_rvalid_q;

  logic timer_load;
  logic timer_done;
  logic starve_at_max;
  logic if_wins;
  logic dm_wins;

  mem_lat_timer #(
    .LOAD_VAL (MEM_LAT)
  ) u_lat_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (timer_load),
    .active_i (state_q == ST_RD_WAIT),
    .done_o   (timer_done)
  );

  // A starved fetch overrides the normal data-side priority.
  assign starve_at_max = (starve_q == STARVE_W'(STARVE_MAX));
  assign if_wins       = if_req_i && (!dm_req_i || starve_at_max);
  assign dm_wins       = dm_req_i && !if_wins;

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    timer_load  = 1'b0;
    if_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (dm_wins) begin
          dm_gnt_o    = 1'b1;
          mem_en_o    = 1'b1;
          mem_we_o    = dm_we_i;
          mem_addr_o  = dm_addr_i;
          mem_wdata_o = dm_wdata_i;
          // Writes complete in the grant cycle; only reads wait for data.
          if (!dm_we_i) begin
            owner_d    = OWN_DM;
            timer_load = 1'b1;
            state_d    = ST_RD_WAIT;
          end
        end else if (if_wins) begin
          if_gnt_o    = 1'b1;
          mem_en_o    = 1'b1;
          mem_addr_o  = if_addr_i;
          mem_wdata_o = dm_wdata_i;
          owner_d     = OWN_IF;
          timer_load  = 1'b1;
          state_d     = ST_RD_WAIT;
        end

        if (!if_req_i || if_gnt_o) begin
          starve_d = '0;
        end else if (dm_gnt_o && !starve_at_max) begin
          starve_d = starve_q + 1'b1;
        end
      end

      ST_RD_WAIT: begin
        if (timer_done) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // NOTE: the read-data registers are reset too, so consumers never see
  // X on rdata before the first capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      if_rvalid_q <= timer_done && (owner_q == OWN_IF);
      dm_rvalid_q <= timer_done && (owner_q == OWN_DM);
      if (timer_done && (owner_q == OWN_IF)) begin
        if_rdata_q <= mem_rdata_i;
      end
      if (timer_done && (owner_q == OWN_DM)) begin
        dm_rdata_q <= mem_rdata_i;
      end
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

  assign stall_if_o = if_req_i && !if_gnt_o;
  assign stall_dm_o = dm_req_i && !dm_gnt_o;

`ifdef ARB_PERF_CNT_EN
  logic [PERF_W-1:0] perf_if_q, perf_dm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q <= '0;
      perf_dm_q <= '0;
    end else begin
      if (stall_if_o) perf_if_q <= perf_sat_inc(perf_if_q);
      if (stall_dm_o) perf_dm_q <= perf_sat_inc(perf_dm_q);
    end
  end

  assign perf_if_stall_o = perf_if_q;
  assign perf_dm_stall_o = perf_dm_q;
`else
  // Stall counters are not built in this configuration.
`endif

endmodule
